dffnsnq_preset_seq: RTL and testbench

DFFNSNQ_PRESET_SEQ -- requirements
Module: dffnsnq_preset_seq

---
 rtl/dffnsnq_preset_seq.sv | 115 +++++++++++
 tb/tb_dffnsnq_preset_seq.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/dffnsnq_preset_seq.sv
// Sequencer for a negative-edge set-flop bank: timed preset pulse with recovery, or a one-cycle load.
// Load: CLKEN at t+1, ACK at t+2. Preset: SETN low t+1..t+P, recovery for REC cycles, then ACK. REQ is ignored while BUSY.
module dffnsnq_preset_seq #(
  parameter int WIDTH = 8,
  parameter int CW    = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             REQ,
  input  logic             OP,
  input  logic [WIDTH-1:0] DIN,
  input  logic [CW-1:0]    PW,
  input  logic [CW-1:0]    REC,
  output logic             BANK_SETN,
  output logic             BANK_CLKEN,
  output logic [WIDTH-1:0] BANK_D,
  output logic             BUSY,
  output logic             ACK
);

  typedef enum logic [2:0] {IDLE, SET, RECOV, LOAD, DONE} state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    pw_q;
  logic [CW-1:0]    rec_q;
  logic             setn_q;
  logic             clken_q;
  logic [WIDTH-1:0] d_q;
  logic             busy_q;
  logic             ack_q;
  logic [CW-1:0]    pw_eff_d;

  // A zero pulse width still gives one cycle of set.
  assign pw_eff_d = (PW == '0) ? CW'(1) : PW;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pw_q    <= '0;
      rec_q   <= '0;
      setn_q  <= 1'b1;
      clken_q <= 1'b0;
      d_q     <= '0;
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (REQ) begin
            busy_q <= 1'b1;
            pw_q   <= pw_eff_d;
            rec_q  <= REC;
            cnt_q  <= CW'(1);
            if (OP) begin
              state_q <= SET;
              setn_q  <= 1'b0;
            end else begin
              state_q <= LOAD;
              clken_q <= 1'b1;
              d_q     <= DIN;
            end
          end
        end
        SET: begin
          if (cnt_q == pw_q) begin
            setn_q <= 1'b1;
            cnt_q  <= CW'(1);
            if (rec_q == '0) begin
              state_q <= DONE;
              ack_q   <= 1'b1;
            end else begin
              state_q <= RECOV;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        RECOV: begin
          if (cnt_q == rec_q) begin
            state_q <= DONE;
            ack_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        LOAD: begin
          clken_q <= 1'b0;
          ack_q   <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          ack_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          setn_q  <= 1'b1;
          clken_q <= 1'b0;
          busy_q  <= 1'b0;
          ack_q   <= 1'b0;
        end
      endcase
    end
  end

  assign BANK_SETN  = setn_q;
  assign BANK_CLKEN = clken_q;
  assign BANK_D     = d_q;
  assign BUSY       = busy_q;
  assign ACK        = ack_q;

endmodule

// File: tb/tb_dffnsnq_preset_seq.sv
// Bench for dffnsnq_preset_seq: per-cycle schedule model plus directed operations with literal expectations.
module tb_dffnsnq_preset_seq;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       REQ = 1'b0;
  logic       OP  = 1'b0;
  logic [7:0] DIN = 8'h00;
  logic [3:0] PW  = 4'd0;
  logic [3:0] REC = 4'd0;
  logic       BANK_SETN, BANK_CLKEN, BUSY, ACK;
  logic [7:0] BANK_D;

  int errs   = 0;
  int checks = 0;

  dffnsnq_preset_seq #(.WIDTH(8), .CW(4)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .OP(OP), .DIN(DIN), .PW(PW), .REC(REC),
    .BANK_SETN(BANK_SETN), .BANK_CLKEN(BANK_CLKEN), .BANK_D(BANK_D),
    .BUSY(BUSY), .ACK(ACK)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an accepted operation is a schedule indexed by k = cycles since the acceptance edge.
  bit       m_valid = 0;
  bit       m_act   = 0;
  bit       m_op    = 0;
  int       m_k, m_p, m_r;
  logic [7:0] m_d = 8'h00;
  bit       prev_ack = 0;

  always @(negedge CLK) begin
    logic e_setn, e_clken, e_busy, e_ack;
    if (m_valid) begin
      e_setn = 1'b1; e_clken = 1'b0; e_busy = 1'b0; e_ack = 1'b0;
      if (m_act) begin
        e_busy = 1'b1;
        if (m_op) begin
          if (m_k <= m_p) e_setn = 1'b0;
          if (m_k == m_p + m_r + 1) e_ack = 1'b1;
        end else begin
          if (m_k == 1) e_clken = 1'b1;
          if (m_k == 2) e_ack = 1'b1;
        end
      end
      check("m_setn",  32'(BANK_SETN),  32'(e_setn));
      check("m_clken", 32'(BANK_CLKEN), 32'(e_clken));
      check("m_busy",  32'(BUSY),       32'(e_busy));
      check("m_ack",   32'(ACK),        32'(e_ack));
      check("m_bank_d", 32'(BANK_D),    32'(m_d));
      check("setn_clken_excl", 32'(BANK_SETN === 1'b0 && BANK_CLKEN === 1'b1), 32'd0);
      check("ack_twice", 32'(prev_ack && ACK === 1'b1), 32'd0);
      prev_ack = (ACK === 1'b1);
    end
    // Inputs are stable from here until the next rising edge, so the edge outcome is known now.
    if (RST) begin
      m_valid = 1;
      m_act   = 0;
      m_d     = 8'h00;
    end else if (m_valid) begin
      if (m_act) begin
        if (m_k == (m_op ? m_p + m_r + 1 : 2)) m_act = 0;
        else m_k++;
      end else if (REQ) begin
        m_act = 1;
        m_k   = 1;
        m_op  = OP;
        m_p   = (PW == 0) ? 1 : int'(PW);
        m_r   = int'(REC);
        if (!OP) m_d = DIN;
      end
    end
  end

  task automatic do_op(input string name, input bit op, input logic [7:0] din,
                       input logic [3:0] pw, input logic [3:0] rec, input bit hold, input bit poke,
                       input int exp_lat, input int exp_setn, input int exp_clken, input logic [7:0] exp_d);
    int  lat = 0, n_setn = 0, n_clken = 0;
    bit  done = 0;
    @(posedge CLK); #1;
    REQ = 1'b1; OP = op; DIN = din; PW = pw; REC = rec;
    while (!done && lat < 40) begin
      @(posedge CLK); #1;
      lat++;
      if (lat == 1) begin
        PW = 4'd0; REC = 4'd0; DIN = ~din;
        if (!hold) REQ = 1'b0;
      end
      if (poke && lat == 2) begin REQ = 1'b1; OP = 1'b0; DIN = 8'hFF; end
      if (poke && lat == 3) REQ = 1'b0;
      @(negedge CLK);
      if (BANK_SETN === 1'b0) n_setn++;
      if (BANK_CLKEN === 1'b1) n_clken++;
      if (ACK === 1'b1) done = 1;
    end
    check({name, "_ack_seen"}, 32'(done), 32'd1);
    check({name, "_ack_lat"},  32'(lat), 32'(exp_lat));
    check({name, "_setn_cyc"}, 32'(n_setn), 32'(exp_setn));
    check({name, "_clken_cyc"}, 32'(n_clken), 32'(exp_clken));
    check({name, "_bank_d"},   32'(BANK_D), 32'(exp_d));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    check("rst_setn",  32'(BANK_SETN),  32'd1);
    check("rst_clken", 32'(BANK_CLKEN), 32'd0);
    check("rst_bank_d", 32'(BANK_D),    32'd0);
    check("rst_busy",  32'(BUSY),       32'd0);
    check("rst_ack",   32'(ACK),        32'd0);

    do_op("load_a5",  1'b0, 8'hA5, 4'd0,  4'd0,  0, 0, 2,  0,  1, 8'hA5);
    do_op("pre_3_2",  1'b1, 8'h11, 4'd3,  4'd2,  0, 0, 6,  3,  0, 8'hA5);
    do_op("pre_0_0",  1'b1, 8'h22, 4'd0,  4'd0,  0, 0, 2,  1,  0, 8'hA5);
    do_op("pre_15_15", 1'b1, 8'h33, 4'd15, 4'd15, 0, 0, 31, 15, 0, 8'hA5);
    do_op("pre_1_3",  1'b1, 8'h44, 4'd1,  4'd3,  0, 0, 5,  1,  0, 8'hA5);
    do_op("busy_poke", 1'b1, 8'h55, 4'd3, 4'd0,  0, 1, 4,  3,  0, 8'hA5);
    do_op("load_5a",  1'b0, 8'h5A, 4'd7,  4'd9,  0, 0, 2,  0,  1, 8'h5A);

    // REQ held: one IDLE cycle after ACK, then the next load is accepted.
    do_op("hold_3c",  1'b0, 8'h3C, 4'd0,  4'd0,  1, 0, 2,  0,  1, 8'h3C);
    DIN = 8'h3C;
    @(posedge CLK); #1;
    @(negedge CLK);
    check("hold_idle_busy", 32'(BUSY), 32'd0);
    @(posedge CLK); #1 REQ = 1'b0;
    @(negedge CLK);
    check("hold_reaccept_clken", 32'(BANK_CLKEN), 32'd1);
    check("hold_reaccept_busy",  32'(BUSY),       32'd1);
    repeat (3) @(posedge CLK);

    // Reset in the second SET cycle of a PW=5 preset.
    #1 REQ = 1'b1; OP = 1'b1; PW = 4'd5; REC = 4'd2;
    @(posedge CLK); #1 REQ = 1'b0;
    @(posedge CLK); #1 RST = 1'b1;
    @(negedge CLK);
    check("abort_in_set", 32'(BANK_SETN), 32'd0);
    @(posedge CLK); #1 RST = 1'b0;
    @(negedge CLK);
    check("abort_setn", 32'(BANK_SETN), 32'd1);
    check("abort_busy", 32'(BUSY), 32'd0);
    check("abort_bank_d", 32'(BANK_D), 32'd0);
    begin
      int acks = 0;
      repeat (12) begin
        @(negedge CLK);
        if (ACK === 1'b1) acks++;
      end
      check("abort_no_ack", 32'(acks), 32'd0);
    end

    // REQ coincident with RST is dropped.
    @(posedge CLK); #1 RST = 1'b1; REQ = 1'b1; OP = 1'b0; DIN = 8'h77;
    @(posedge CLK); #1 RST = 1'b0; REQ = 1'b0;
    @(negedge CLK);
    check("rstreq_clken", 32'(BANK_CLKEN), 32'd0);
    check("rstreq_busy",  32'(BUSY), 32'd0);
    check("rstreq_bank_d", 32'(BANK_D), 32'd0);

    // First edge after reset release accepts.
    @(posedge CLK); #1 RST = 1'b1;
    @(posedge CLK); #1 RST = 1'b0; REQ = 1'b1; OP = 1'b0; DIN = 8'hC3;
    @(posedge CLK); #1 REQ = 1'b0;
    @(negedge CLK);
    check("post_rst_clken", 32'(BANK_CLKEN), 32'd1);
    check("post_rst_bank_d", 32'(BANK_D), 32'hC3);
    repeat (4) @(posedge CLK);
    @(negedge CLK);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
